dec_scan_n: RTL and testbench
=============================

// Module: dec_scan_n
// PURPOSE
//   Parametrised, registered one-hot decoder with enable and two modes.
//   Direct mode decodes the in bus to a one-hot out bus with 1-cycle latency.
//   Scan mode free-runs an internal index through all outputs at a programmable rate.
//   Used as digit/row select for multiplexed 7-seg and LED-matrix drivers, and as a general N-to-2^N decoder.
// PARAMETERS
//   IN_W       3     width of in and sel; legal range 1..8
//   NUM_OUT    8     number of outputs; 2 <= NUM_OUT <= 2**IN_W
//   DIV        1000  scan prescaler: clk cycles per index step; DIV >= 1
//   ACTIVE_LOW 0     1 = out is inverted (active output low, idle outputs high)
// PORTS
//   clk    in   1        single clock; all state updates on its rising edge
//   rst    in   1        synchronous reset, active-high
//   en     in   1        1 = decode active; 0 = all outputs inactive
//   mode   in   1        0 = direct, 1 = scan
//   load   in   1        scan mode only: load in into the index and restart the prescaler
//   in     in   IN_W     index to decode (direct) or to load (scan)
//   out    out  NUM_OUT  registered one-hot select
//   sel    out  IN_W     registered current index
//   tick   out  1        1-cycle pulse on the edge where scan advances sel
// BEHAVIOUR
//   - Polarity: "inactive" means 0 when ACTIVE_LOW=0, and 1 when ACTIVE_LOW=1. All rules below are stated as active-high; ACTIVE_LOW=1 inverts out only.
//   - Reset (rst=1 at an edge): out=all inactive, sel=0, tick=0, prescaler=0. Reset has priority over all other inputs.
//   - en=0: next edge out=all inactive, tick=0; sel and prescaler hold.
//     - On re-enable, out=onehot(sel) from the next edge; scan resumes from the held prescaler value.
//   - Direct mode (mode=0, en=1):
//     - Each edge: if in<NUM_OUT then out=onehot(in) and sel=in; otherwise out=0 and sel holds.
//     - Latency 1 cycle; tick=0; prescaler held at 0; load ignored.
//   - Scan mode (mode=1, en=1):
//     - Prescaler counts 0..DIV-1, then wraps to 0.
//     - On the wrap edge: sel = (sel==NUM_OUT-1) ? 0 : sel+1, and tick=1 for that cycle only.
//     - out=onehot(sel) always, so out and sel update on the same edge.
//     - DIV=1: sel advances every cycle and tick is held at 1.
//   - load=1 in scan mode:
//     - sel = (in<NUM_OUT) ? in : 0; prescaler=0; tick=0.
//     - Load beats a simultaneous prescaler wrap.
//   - Mode changes:
//     - 0->1: scan starts from the current sel with prescaler=0; first step after DIV cycles.
//     - 1->0: prescaler cleared; direct decode applies on the same edge.
//   - sel never exceeds NUM_OUT-1.
//   - out has exactly one bit active when en=1 and the index is valid; otherwise none.
// STRUCTURE
//   - Shared package/header dec_pkg holds:
//     - clog2 function
//     - onehot(idx, NUM_OUT) decode function
//     - MODE_DIRECT=1'b0 and MODE_SCAN=1'b1 constants
//   - One sub-module, tick_gen, is the DIV prescaler.
//     - Ports: clk, rst, clr, run; outputs cnt and wrap.
//     - Counter width = clog2(DIV), minimum 1.
//   - The top holds the sel register, the out register and the mode/load/en priority logic.
// TESTING (IN_W=3, NUM_OUT=6, DIV=4, ACTIVE_LOW=0 unless noted)
//   1. Reset with en=1, mode=0, in=5 -> out=000000 and sel=0 while rst=1; one edge after release, out=100000 and sel=5.
//   2. Direct mode, in=6 then in=7 -> out=000000 and sel stays 5; in=0 -> out=000001 one cycle later.
//   3. Scan mode from sel=4 -> tick every 4th cycle; sel sequence 5,0,1 (wrap at 5); out=100000 then 000001.
//   4. Scan mode, load=1 with in=2 on a wrap cycle -> sel=2, tick=0, next advance 4 cycles later.
//   5. Scan mode, en=0 for 3 cycles -> out=000000, sel holds; after en=1, out=onehot(sel) and the step comes at the held count.
//   6. ACTIVE_LOW=1, DIV=1 -> after reset out=111111; scan gives 111110, 111101, ...; tick stays 1.

Source files
------------

// File: rtl/dec_pkg.sv
`default_nettype none
// ==== dec_pkg : shared constants and helpers for dec_scan_n  (rev 1.0) ====
package dec_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest decode the onehot helper can build (IN_W up to 8).
  localparam int MAX_OUT = 256;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int w = value - 1; w > 0; w = w >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Indices at or above num_out decode to all zeros.
  function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx,
                                                input int unsigned num_out);
    logic [MAX_OUT-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_OUT; i++) begin
      r[i] = (i < num_out) && (i == idx);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_scan_n_tick_gen.sv
`default_nettype none
// ==== tick_gen : DIV-cycle prescaler with clear and run  (rev 1.0) ====
module tick_gen
  import dec_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             run_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             w_at_last;

  assign w_at_last = (cnt_q == c_last);
  // Clear wins over run, so a wrap is never reported on a clearing edge.
  assign wrap_o    = run_i && !clr_i && w_at_last;
  assign cnt_o     = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= w_at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dec_scan_n.sv
`default_nettype none
// ==== dec_scan_n : registered one-hot decoder, direct and scan modes  (rev 1.0) ====
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int IN_W       = 3,
  parameter int NUM_OUT    = 8,
  parameter int DIV        = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic               load_i,
  input  logic [IN_W-1:0]    in_i,
  output logic [NUM_OUT-1:0] out_o,
  output logic [IN_W-1:0]    sel_o,
  output logic               tick_o
);

  localparam logic [IN_W:0]      c_num  = (IN_W + 1)'(NUM_OUT);
  localparam logic [IN_W-1:0]    c_last = IN_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] c_idle = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [IN_W-1:0]    sel_q, sel_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               tick_q, tick_d;

  logic w_scan;
  logic w_in_ok;
  logic w_run;
  logic w_clr;
  logic w_wrap;

  assign w_scan  = (mode_i == MODE_SCAN);
  assign w_in_ok = ({1'b0, in_i} < c_num);
  // Prescaler only advances in an enabled, non-loading scan; direct mode and loads zero it.
  assign w_run   = en_i && w_scan && !load_i;
  assign w_clr   = en_i && (!w_scan || load_i);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_clr),
    .run_i  (w_run),
    .cnt_o  (),
    .wrap_o (w_wrap)
  );

  always_comb begin
    sel_d  = sel_q;
    out_d  = c_idle;
    tick_d = 1'b0;
    if (en_i && !w_scan) begin
      if (w_in_ok) begin
        sel_d = in_i;
        out_d = c_idle ^ NUM_OUT'(onehot(32'(in_i), NUM_OUT));
      end
    end else if (en_i) begin
      if (load_i) begin
        sel_d = w_in_ok ? in_i : '0;
      end else if (w_wrap) begin
        sel_d  = (sel_q == c_last) ? '0 : sel_q + IN_W'(1);
        tick_d = 1'b1;
      end
      out_d = c_idle ^ NUM_OUT'(onehot(32'(sel_d), NUM_OUT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      out_q  <= c_idle;
      tick_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_o  = out_q;
  assign sel_o  = sel_q;
  assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_n.sv
`default_nettype none
// ==== tb_dec_scan_n : scoreboard bench for dec_scan_n (DIV=4 active-high, DIV=1 active-low)  (rev 1.0) ====
module tb_dec_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic       en   = 1'b1;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [2:0] in   = 3'd5;

  logic [5:0] out_a, out_b;
  logic [2:0] sel_a, sel_b;
  logic       tick_a, tick_b;

  dec_scan_n #(.IN_W(3), .NUM_OUT(6), .DIV(4), .ACTIVE_LOW(0)) u_dut_a (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .load_i(load), .in_i(in),
    .out_o(out_a), .sel_o(sel_a), .tick_o(tick_a)
  );

  dec_scan_n #(.IN_W(3), .NUM_OUT(6), .DIV(1), .ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .load_i(load), .in_i(in),
    .out_o(out_b), .sel_o(sel_b), .tick_o(tick_b)
  );

  int checks = 0;
  int errors = 0;
  int sa = 0, ca = 0, sb = 0, cb = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed {out,sel,tick}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Reference behaviour for a 6-output, IN_W=3 decoder; result is {out,sel,tick}.
  task automatic model(input int div, input bit pol, input logic r, e, m, l,
                       input logic [2:0] i, inout int s, inout int c,
                       output logic [9:0] x);
    logic [5:0] o;
    logic       t;
    o = 6'b0;
    t = 1'b0;
    if (r) begin
      s = 0;
      c = 0;
    end else if (e && !m) begin
      c = 0;
      if (i < 3'd6) begin
        s = int'(i);
        o = 6'b1 << s;
      end
    end else if (e) begin
      if (l) begin
        s = (i < 3'd6) ? int'(i) : 0;
        c = 0;
      end else if (c == div - 1) begin
        c = 0;
        s = (s == 5) ? 0 : s + 1;
        t = 1'b1;
      end else begin
        c++;
      end
      o = 6'b1 << s;
    end
    if (pol) o = ~o;
    x = {o, 3'(s), t};
  endtask

  task automatic step(input logic r, e, m, l, input logic [2:0] i);
    logic [9:0] ea, eb;
    @(negedge clk);
    rst = r; en = e; mode = m; load = l; in = i;
    model(4, 1'b0, r, e, m, l, i, sa, ca, ea);
    qa.push_back(ea);
    model(1, 1'b1, r, e, m, l, i, sb, cb, eb);
    qb.push_back(eb);
    @(posedge clk);
    #1;
    chk("sb_a", {out_a, sel_a, tick_a}, qa.pop_front());
    chk("sb_b", {out_b, sel_b, tick_b}, qb.pop_front());
  endtask

  initial begin
    // Reset with direct decode of 5 pending
    step(1, 1, 0, 0, 3'd5);
    chk("rst_a", {out_a, sel_a, tick_a}, {6'b000000, 3'd0, 1'b0});
    chk("rst_b", {out_b, sel_b, tick_b}, {6'b111111, 3'd0, 1'b0});
    step(0, 1, 0, 0, 3'd5);
    chk("rel_a", {out_a, sel_a, tick_a}, {6'b100000, 3'd5, 1'b0});

    // Out-of-range direct indices
    step(0, 1, 0, 0, 3'd6);
    chk("inv6_a", {out_a, sel_a, tick_a}, {6'b000000, 3'd5, 1'b0});
    chk("inv6_b", {out_b, sel_b, tick_b}, {6'b111111, 3'd5, 1'b0});
    step(0, 1, 0, 0, 3'd7);
    chk("inv7_a", {out_a, sel_a, tick_a}, {6'b000000, 3'd5, 1'b0});
    step(0, 1, 0, 0, 3'd0);
    chk("dir0_a", {out_a, sel_a, tick_a}, {6'b000001, 3'd0, 1'b0});
    step(0, 1, 0, 0, 3'd4);

    // Scan from sel=4, wrapping through 5
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 1, 0, 3'd0);
      if (k == 4)  chk("scan5_a", {out_a, sel_a, tick_a}, {6'b100000, 3'd5, 1'b1});
      if (k == 5)  chk("notick_a", {out_a, sel_a, tick_a}, {6'b100000, 3'd5, 1'b0});
      if (k == 8)  chk("scan0_a", {out_a, sel_a, tick_a}, {6'b000001, 3'd0, 1'b1});
      if (k == 12) chk("scan1_a", {out_a, sel_a, tick_a}, {6'b000010, 3'd1, 1'b1});
    end

    // Load coinciding with a wrap
    repeat (3) step(0, 1, 1, 0, 3'd0);
    step(0, 1, 1, 1, 3'd2);
    chk("load_a", {out_a, sel_a, tick_a}, {6'b000100, 3'd2, 1'b0});
    repeat (3) step(0, 1, 1, 0, 3'd0);
    chk("ldhold_a", {out_a, sel_a, tick_a}, {6'b000100, 3'd2, 1'b0});
    step(0, 1, 1, 0, 3'd0);
    chk("ldadv_a", {out_a, sel_a, tick_a}, {6'b001000, 3'd3, 1'b1});

    // Disable mid-count, then resume from the held prescaler
    repeat (2) step(0, 1, 1, 0, 3'd0);
    repeat (3) step(0, 0, 1, 0, 3'd0);
    chk("off_a", {out_a, sel_a, tick_a}, {6'b000000, 3'd3, 1'b0});
    step(0, 1, 1, 0, 3'd0);
    chk("on_a", {out_a, sel_a, tick_a}, {6'b001000, 3'd3, 1'b0});
    step(0, 1, 1, 0, 3'd0);
    chk("onstep_a", {out_a, sel_a, tick_a}, {6'b010000, 3'd4, 1'b1});

    // Out-of-range load, then mode 1->0->1
    step(0, 1, 1, 1, 3'd7);
    chk("ldinv_a", {out_a, sel_a, tick_a}, {6'b000001, 3'd0, 1'b0});
    step(0, 1, 1, 0, 3'd0);
    step(0, 1, 0, 0, 3'd3);
    chk("todir_a", {out_a, sel_a, tick_a}, {6'b001000, 3'd3, 1'b0});
    repeat (4) step(0, 1, 1, 0, 3'd0);
    chk("toscan_a", {out_a, sel_a, tick_a}, {6'b010000, 3'd4, 1'b1});

    // Active-low, DIV=1 scanning after a fresh reset
    step(1, 1, 1, 0, 3'd0);
    chk("rst2_b", {out_b, sel_b, tick_b}, {6'b111111, 3'd0, 1'b0});
    step(0, 1, 1, 1, 3'd0);
    chk("al0_b", {out_b, sel_b, tick_b}, {6'b111110, 3'd0, 1'b0});
    step(0, 1, 1, 0, 3'd0);
    chk("al1_b", {out_b, sel_b, tick_b}, {6'b111101, 3'd1, 1'b1});
    step(0, 1, 1, 0, 3'd0);
    chk("al2_b", {out_b, sel_b, tick_b}, {6'b111011, 3'd2, 1'b1});
    repeat (4) step(0, 1, 1, 0, 3'd0);
    chk("alwrap_b", {out_b, sel_b, tick_b}, {6'b111110, 3'd0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
